i2c_bus_cond_detect: RTL and testbench



---
 rtl/i2c_pkg.sv | 17 +
 rtl/i2c_glitch_filter.sv | 54 +++++
 rtl/i2c_bus_cond_detect.sv | 136 +++++++++++++
 tb/tb_i2c_bus_cond_detect.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C bus-condition front end.
package i2c_pkg;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_BUSY = 1'b1
  } bus_state_e;

  localparam int I2C_SYNC_STAGES = 2;
  localparam int I2C_FILTER_LEN  = 4;

  // Bits needed for a counter that holds 0 .. max_val-1 (at least 1 bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/i2c_glitch_filter.sv
// Input synchroniser followed by a stability counter. The filtered output
// only follows the synchronised line after it has differed for FILTER_LEN
// consecutive cycles, so shorter glitches never reach the output.
// Every flop resets to the idle-bus level (1), the counter to 0.
module i2c_glitch_filter
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = I2C_SYNC_STAGES,
  parameter int FILTER_LEN  = I2C_FILTER_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic filt_o
);

  localparam int CW = cnt_width(FILTER_LEN);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];
  assign filt_o = filt_q;

  // Synchroniser shift chain, oldest sample at the top bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
  end

  // Count cycles of disagreement; toggle and restart once FILTER_LEN is reached.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (synced != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) filt_d = ~filt_q;
      else                              cnt_d  = cnt_q + 1'b1;
    end
  end

  // Filter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

endmodule

// File: rtl/i2c_bus_cond_detect.sv
// I2C bus-condition detector: filtered SCL/SDA, SCL edge strobes,
// START/STOP pulses, bus-busy tracking and sticky arbitration loss.
// Optional build macro I2C_BUS_TIMEOUT_EN adds an SCL-low bus timeout
// that pulses bus_timeout and drops the bus back to IDLE.
module i2c_bus_cond_detect
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES    = I2C_SYNC_STAGES,
  parameter int FILTER_LEN     = I2C_FILTER_LEN,
  parameter int TIMEOUT_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  input  logic sda_out,
  input  logic sda_oe,
  input  logic arb_clr,
  output logic scl_filt,
  output logic sda_filt,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_detected,
  output logic stop_detected,
  output logic bus_busy,
  output logic arbitration_lost,
  output logic bus_timeout
);

  if (SYNC_STAGES < 2 || FILTER_LEN < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("i2c_bus_cond_detect: illegal parameter value");
  end

  logic       scl_f, sda_f;
  logic       scl_d_q, sda_d_q;
  logic       scl_rise_q, scl_fall_q, start_q, stop_q, arb_q, tout_q;
  logic       arb_d;
  logic       scl_hi_stable, start_c, stop_c, timeout_c, arb_set, arb_clear;
  bus_state_e state_q, state_d;

  i2c_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk(clk), .rst_n(rst_n), .line_i(scl_in), .filt_o(scl_f)
  );

  i2c_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk(clk), .rst_n(rst_n), .line_i(sda_in), .filt_o(sda_f)
  );

  // SCL high now and last cycle: a simultaneous SCL edge disqualifies any condition.
  assign scl_hi_stable = scl_f & scl_d_q;
  assign start_c       = scl_hi_stable & ~sda_f &  sda_d_q;
  assign stop_c        = scl_hi_stable &  sda_f & ~sda_d_q;

`ifdef I2C_BUS_TIMEOUT_EN
  localparam int TW = cnt_width(TIMEOUT_CYCLES);
  logic [TW-1:0] to_cnt_q;

  assign timeout_c = (state_q == BUS_BUSY) && !scl_f && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Count consecutive BUSY cycles with SCL low; any SCL high restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                to_cnt_q <= '0;
    else if ((state_q == BUS_BUSY) && !scl_f)  to_cnt_q <= timeout_c ? '0 : to_cnt_q + 1'b1;
    else                                       to_cnt_q <= '0;
  end
`else
  assign timeout_c = 1'b0;
`endif

  // Delayed copies of the filtered lines plus all registered pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_d_q    <= 1'b1;
      sda_d_q    <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      tout_q     <= 1'b0;
    end else begin
      scl_d_q    <= scl_f;
      sda_d_q    <= sda_f;
      scl_rise_q <= scl_f & ~scl_d_q;
      scl_fall_q <= ~scl_f & scl_d_q;
      start_q    <= start_c;
      stop_q     <= stop_c;
      tout_q     <= timeout_c;
    end
  end

  // Bus state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BUS_IDLE;
    else        state_q <= state_d;
  end

  // Next bus state: START claims the bus, STOP releases it, timeout forces IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BUS_IDLE: if (start_c) state_d = BUS_BUSY;
      BUS_BUSY: if (stop_c)  state_d = BUS_IDLE;
      default:               state_d = BUS_IDLE;
    endcase
    if (timeout_c) state_d = BUS_IDLE;
  end

  // Loss: line low while we release SDA on an SCL rise, or a START/STOP
  // whose SDA direction contradicts what we are driving.
  always_comb begin
    arb_set   = (scl_rise_q & (state_q == BUS_BUSY) & sda_oe & sda_out & ~sda_f)
              | (start_c & sda_oe &  sda_out)
              | (stop_c  & sda_oe & ~sda_out);
    arb_clear = arb_clr | stop_c | timeout_c;
    arb_d     = arb_q;
    if (arb_set)        arb_d = 1'b1;
    else if (arb_clear) arb_d = 1'b0;
  end

  // Sticky arbitration-loss flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) arb_q <= 1'b0;
    else        arb_q <= arb_d;
  end

  assign scl_filt         = scl_f;
  assign sda_filt         = sda_f;
  assign scl_rise         = scl_rise_q;
  assign scl_fall         = scl_fall_q;
  assign start_detected   = start_q;
  assign stop_detected    = stop_q;
  assign bus_busy         = (state_q == BUS_BUSY);
  assign arbitration_lost = arb_q;
  assign bus_timeout      = tout_q;

endmodule

// File: tb/tb_i2c_bus_cond_detect.sv
// Bench for i2c_bus_cond_detect. Expected bus events (START/STOP/timeout)
// are queued when the line change is driven and checked when the DUT
// pulses; level outputs are checked directly at chosen cycles.
module tb_i2c_bus_cond_detect;

  localparam int SYNC   = 2;
  localparam int FLEN   = 4;
  localparam int TOUT   = 100;
  localparam int SETTLE = 10;

  localparam logic [2:0] EV_START = 3'b001;
  localparam logic [2:0] EV_STOP  = 3'b010;
  localparam logic [2:0] EV_TOUT  = 3'b100;
  localparam logic [2:0] EV_NONE  = 3'b000;

  logic clk, rst_n, scl_in, sda_in, sda_out, sda_oe, arb_clr;
  logic scl_filt, sda_filt, scl_rise, scl_fall, start_detected, stop_detected;
  logic bus_busy, arbitration_lost, bus_timeout;

  int n_cmp = 0;
  int n_err = 0;
  int rise_cnt = 0;
  logic [2:0] exp_q[$];

  i2c_bus_cond_detect #(.SYNC_STAGES(SYNC), .FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl_in), .sda_in(sda_in),
    .sda_out(sda_out), .sda_oe(sda_oe), .arb_clr(arb_clr),
    .scl_filt(scl_filt), .sda_filt(sda_filt), .scl_rise(scl_rise), .scl_fall(scl_fall),
    .start_detected(start_detected), .stop_detected(stop_detected),
    .bus_busy(bus_busy), .arbitration_lost(arbitration_lost), .bus_timeout(bus_timeout)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic step(input logic scl, input logic sda, input logic [2:0] ev);
    if (ev != EV_NONE) exp_q.push_back(ev);
    scl_in = scl;
    sda_in = sda;
    tick(SETTLE);
  endtask

  // Scoreboard monitor: every event pulse must match the oldest expected event.
  always @(negedge clk) begin
    logic [2:0] code;
    if (rst_n) begin
      code = {bus_timeout, stop_detected, start_detected};
      if (code != EV_NONE) begin
        if (exp_q.size() == 0) check_val("unexpected_event", {29'd0, code}, 32'd0);
        else                   check_val("event", {29'd0, code}, {29'd0, exp_q.pop_front()});
      end
      if (scl_rise) rise_cnt++;
    end
  end

  initial begin
    int lat;
    rst_n = 1'b0; scl_in = 1'b0; sda_in = 1'b0;
    sda_out = 1'b1; sda_oe = 1'b0; arb_clr = 1'b0;

    // Reset with both lines low: outputs at idle values.
    tick(3);
    check_val("rst_scl_filt", scl_filt, 1);
    check_val("rst_sda_filt", sda_filt, 1);
    check_val("rst_busy", bus_busy, 0);
    check_val("rst_arb", arbitration_lost, 0);
    check_val("rst_start", start_detected, 0);
    rst_n = 1'b1;
    // Filtered lines follow after SYNC+FLEN cycles; both fall together -> no START.
    tick(SYNC + FLEN - 1);
    check_val("post_rst_scl_hold", scl_filt, 1);
    check_val("post_rst_sda_hold", sda_filt, 1);
    tick(1);
    check_val("post_rst_scl_low", scl_filt, 0);
    check_val("post_rst_sda_low", sda_filt, 0);
    tick(4);
    check_val("post_rst_busy", bus_busy, 0);
    step(1'b1, 1'b1, EV_NONE);

    // 3-cycle SDA glitch with SCL high is suppressed.
    sda_in = 1'b0;
    tick(3);
    sda_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check_val("glitch_sda_filt", sda_filt, 1);
    end

    // Real START: filtered edge after SYNC+FLEN cycles, registered pulse one later.
    exp_q.push_back(EV_START);
    sda_in = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (start_detected && lat == 0) lat = i;
    end
    check_val("start_latency", lat, SYNC + FLEN + 1);
    check_val("start_busy", bus_busy, 1);

    // Two SCL pulses, repeated START, then STOP.
    step(1'b0, 1'b0, EV_NONE);
    rise_cnt = 0;
    step(1'b1, 1'b0, EV_NONE);
    step(1'b0, 1'b0, EV_NONE);
    step(1'b1, 1'b0, EV_NONE);
    step(1'b0, 1'b0, EV_NONE);
    check_val("scl_rise_count", rise_cnt, 2);
    step(1'b0, 1'b1, EV_NONE);
    step(1'b1, 1'b1, EV_NONE);
    step(1'b1, 1'b0, EV_START);
    check_val("rep_start_busy", bus_busy, 1);
    step(1'b0, 1'b0, EV_NONE);
    step(1'b1, 1'b0, EV_NONE);
    step(1'b1, 1'b1, EV_STOP);
    check_val("stop_busy", bus_busy, 0);

    // Arbitration: we release SDA, another master holds it low at SCL rise.
    step(1'b1, 1'b0, EV_START);
    step(1'b0, 1'b0, EV_NONE);
    sda_oe = 1'b1; sda_out = 1'b1;
    step(1'b0, 1'b0, EV_NONE);
    scl_in = 1'b1;
    tick(SYNC + FLEN + 1);
    check_val("arb_scl_rise", scl_rise, 1);
    check_val("arb_before", arbitration_lost, 0);
    tick(1);
    check_val("arb_set", arbitration_lost, 1);
    tick(2);
    // arb_clr coinciding with a new loss: set wins.
    scl_in = 1'b0;
    tick(SETTLE);
    scl_in = 1'b1;
    tick(SYNC + FLEN + 1);
    arb_clr = 1'b1;
    tick(1);
    arb_clr = 1'b0;
    check_val("arb_set_over_clr", arbitration_lost, 1);
    tick(2);
    sda_oe = 1'b0;
    step(1'b1, 1'b1, EV_STOP);
    check_val("arb_stop_clr", arbitration_lost, 0);
    check_val("arb_stop_busy", bus_busy, 0);

    // Foreign repeated START while we release SDA, then plain arb_clr.
    step(1'b1, 1'b0, EV_START);
    step(1'b0, 1'b0, EV_NONE);
    step(1'b0, 1'b1, EV_NONE);
    step(1'b1, 1'b1, EV_NONE);
    sda_oe = 1'b1; sda_out = 1'b1;
    step(1'b1, 1'b0, EV_START);
    check_val("arb_foreign_start", arbitration_lost, 1);
    sda_oe = 1'b0;
    arb_clr = 1'b1;
    tick(1);
    arb_clr = 1'b0;
    tick(1);
    check_val("arb_clr", arbitration_lost, 0);
    step(1'b0, 1'b0, EV_NONE);
    step(1'b1, 1'b0, EV_NONE);
    step(1'b1, 1'b1, EV_STOP);

    // Simultaneous SCL/SDA edges produce no condition.
    step(1'b0, 1'b0, EV_NONE);
    check_val("simul_busy", bus_busy, 0);
    check_val("simul_sda_filt", sda_filt, 0);
    step(1'b1, 1'b1, EV_NONE);
    check_val("simul_busy_after", bus_busy, 0);

    // SCL held low while BUSY.
    step(1'b1, 1'b0, EV_START);
`ifdef I2C_BUS_TIMEOUT_EN
    exp_q.push_back(EV_TOUT);
    step(1'b0, 1'b0, EV_NONE);
    tick(TOUT + 20);
    check_val("timeout_busy", bus_busy, 0);
`else
    step(1'b0, 1'b0, EV_NONE);
    tick(TOUT + 20);
    check_val("no_timeout_busy", bus_busy, 1);
    check_val("no_timeout_pulse", bus_timeout, 0);
`endif
    step(1'b1, 1'b0, EV_NONE);
    step(1'b1, 1'b1, EV_STOP);
    check_val("final_busy", bus_busy, 0);

    tick(5);
    check_val("leftover_events", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
